ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Loader that drives the configuration-chain interface (ccff_head in, ccff_tail out) of logical tiles such as the ble4 LUT4 plus output mux.
- Accepts bitstream words over a valid/ready handshake and serializes them MSB-first onto ccff_head.
- Issues one shift-enable per bit; the top level uses it to gate prog_clk into the chain.
- Stops after exactly CHAIN_LEN bits and signals completion.

Parameters:
- CHAIN_LEN, 18: total configuration bits in the chain (16 LUT4 bits + 2 mux SRAM bits for one ble4).
- WORD_W, 8: width of an input bitstream word.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter (derived, not overridden).

Ports:
- prog_clk  input  1  sole clock; rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load.
- abort  input  1  synchronous cancel of a load in progress.
- word_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  input  1  word_data is valid.
- word_ready  output  1  loader accepts word_data this cycle.
- ccff_head  output  1  serial data into the chain head.
- ccff_tail  input  1  serial data from the chain tail (used only with readback).
- chain_shift_en  output  1  the chain shifts on the prog_clk edge that ends this cycle.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last bit has shifted.
- err  output  1  sticky abort flag; cleared by an accepted start.

Behaviour:
- Reset, synchronous and active-high: state goes to IDLE; bit counter, word bit index and shift register clear to 0.
- Reset values: word_ready=0, ccff_head=0, chain_shift_en=0, busy=0, done=0, err=0.
- Reset during any state returns the block to IDLE with no done pulse. Partial chain contents are left as they are.
- States:
  - IDLE: start=1 -> LOAD; err clears to 0 and the bit counter clears to 0. start is ignored in every other state.
  - LOAD: word_ready=1. On word_valid&&word_ready, latch word_data, set bit index to WORD_W-1, go to SHIFT next cycle. If word_valid=0, stay in LOAD with chain_shift_en=0 and ccff_head=0.
  - SHIFT: chain_shift_en=1 and ccff_head=word[bit index] every cycle; the bit counter increments each cycle.
    - When the counter reaches CHAIN_LEN -> DONE.
    - Otherwise, when bit index = 0 -> LOAD.
    - Otherwise the bit index decrements.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Partial last word: if CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the final word are shifted. The remaining bits are dropped and no further word is requested.
- Throughput: one bit per SHIFT cycle, plus one LOAD cycle per word (minimum). Total minimum time from start to done = 1 + ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles.
- abort=1 in LOAD, SHIFT or DONE: next state is IDLE, err=1, no done pulse. chain_shift_en is 0 from the next cycle onward.
- abort in IDLE has no effect.
- abort and reset asserted together: reset wins, so err=0.
- chain_shift_en and ccff_head are registered outputs, so they change only on prog_clk edges and are glitch-free for gating.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- When defined, three extra ports exist:
  - rb_data, output, WORD_W: readback word.
  - rb_valid, output, 1: one-cycle pulse per readback word.
  - rb_ready, input, 1.
- Readback behaviour: in every SHIFT cycle, ccff_tail is sampled into a WORD_W readback shift register, MSB-first. This captures the old chain contents in tail-first order.
  - rb_valid pulses for one cycle each time WORD_W bits have been collected, and once more at DONE for any partial word, left-aligned with zeros below.
  - rb_ready=0 while rb_valid=1 stalls the FSM in its current state with chain_shift_en=0.
- When the macro is not defined: none of these ports exist, ccff_tail is unused, and the FSM never stalls except on word_valid.

Decomposition:
- Package ccff_loader_pkg holds:
  - state enum {IDLE, LOAD, SHIFT, DONE}, 2 bits;
  - the counter-width helper function;
  - default CHAIN_LEN and WORD_W constants.
- One sub-module, ccff_word_serializer: a parallel-load, MSB-first PISO with a bit-index output. It is instantiated once for ccff_head, and a second time as an SIPO variant under CCFF_READBACK_EN.

Test Plan (CHAIN_LEN=18, WORD_W=8):
1. Reset: assert reset for 2 cycles with start=1 -> all outputs 0, busy stays 0.
2. Full load: start at cycle 0, then words 0xA5, 0x3C, 0xC0 with word_valid held high.
   - word_ready in cycles 1, 10 and 19.
   - chain_shift_en in cycles 2-9, 11-18 and 20-21.
   - ccff_head = 1010_0101_0011_1100_11.
   - done in cycle 22 only; exactly 18 shift-enables.
3. Valid stall: hold word_valid=0 for 5 cycles in the second LOAD -> chain_shift_en=0, ccff_head=0 during the stall; bit stream unchanged; done is delayed by 5 cycles.
4. Abort: abort at the 5th shift of word 2 -> IDLE next cycle, err=1, busy=0, no done. A new start clears err and a full load completes.
5. Start while busy and mid-shift reset: start pulses during SHIFT are ignored (the count is still 18). Reset at shift 7 -> IDLE, all outputs 0 on the next cycle.
6. CCFF_READBACK_EN: chain model preloaded with 0x2D71 in the upper 16 bits and 2'b10 in the last 2 bits; rb_ready held low for 3 cycles once.
   - rb_data receives the tail-first words of the preload, with the final partial word left-aligned.
   - chain_shift_en pauses for the 3 stalled cycles.

Source files
------------

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and defaults for the configuration-chain loader.
// The state encoding is also used by checkers bound to the loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ccff_state_e;

  localparam int unsigned CCFF_CHAIN_LEN_DEF = 18;
  localparam int unsigned CCFF_WORD_W_DEF    = 8;

  // Counter must be able to hold the value n itself, not just n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_chain_loader_word_serializer.sv
// Word-wide shift register walked by a bit index, MSB first. Parallel load plus
// index step gives a PISO (bit_o/next_bit_o); with cap_i set it also works as a SIPO.
module ccff_word_serializer #(
  parameter int unsigned W = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic [W-1:0]         par_i,
  input  logic                 step_i,
  input  logic                 cap_i,
  input  logic                 ser_i,
  output logic [W-1:0]         par_o,
  output logic [$clog2(W)-1:0] idx_o,
  output logic                 next_bit_o
);

  localparam int unsigned IW = $clog2(W);

  logic [W-1:0]  data_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      data_q <= par_i;
      idx_q  <= IW'(W - 1);
    end else if (step_i) begin
      if (cap_i) begin
        // First capture of a word clears the rest, so a partial word stays left-aligned.
        if (idx_q == IW'(W - 1)) data_q <= {ser_i, {(W-1){1'b0}}};
        else                     data_q[idx_q] <= ser_i;
      end
      idx_q <= (idx_q == '0) ? IW'(W - 1) : idx_q - IW'(1);
    end
  end

  assign par_o      = data_q;
  assign idx_o      = idx_q;
  assign next_bit_o = data_q[idx_q - IW'(1)];

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words MSB-first onto a configuration chain, one shift-enable per bit.
// Define CCFF_READBACK_EN to also capture the old chain contents from ccff_tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter  int unsigned CHAIN_LEN = CCFF_CHAIN_LEN_DEF,
  parameter  int unsigned WORD_W    = CCFF_WORD_W_DEF,
  localparam int unsigned CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready
`endif
);

  // Handshake: a word transfers on a prog_clk edge where word_valid && word_ready;
  // rb_data likewise transfers where rb_valid && rb_ready, and rb_valid holds until then.

  ccff_state_e                 state_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        word_ready_q, head_q, shift_en_q, done_q, err_q;
  logic                        stall, accept, step, start_acc, last_bit, final_bit, next_bit;
  logic [$clog2(WORD_W)-1:0]   idx;
  logic [WORD_W-1:0]           unused_head_par;

  assign cnt_d     = cnt_q + CNT_W'(1);
  assign final_bit = (cnt_d == CNT_W'(CHAIN_LEN));
  assign last_bit  = (idx == '0);
  assign start_acc = (state_q == IDLE) && start;
  assign accept    = (state_q == LOAD) && word_valid && !stall && !abort;
  assign step      = (state_q == SHIFT) && !stall && !abort;

  ccff_word_serializer #(.W(WORD_W)) u_head (
    .clk_i      (prog_clk),
    .reset_i    (reset),
    .load_i     (accept),
    .par_i      (word_data),
    .step_i     (step),
    .cap_i      (1'b0),
    .ser_i      (1'b0),
    .par_o      (unused_head_par),
    .idx_o      (idx),
    .next_bit_o (next_bit)
  );

  // Outputs are set from the next state so the chain sees them straight from flops.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      word_ready_q <= 1'b0;
      head_q       <= 1'b0;
      shift_en_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_q      <= IDLE;
      err_q        <= 1'b1;
      word_ready_q <= 1'b0;
      head_q       <= 1'b0;
      shift_en_q   <= 1'b0;
      done_q       <= 1'b0;
    end else if (!stall) begin
      word_ready_q <= 1'b0;
      head_q       <= 1'b0;
      shift_en_q   <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q      <= LOAD;
          err_q        <= 1'b0;
          cnt_q        <= '0;
          word_ready_q <= 1'b1;
        end
        LOAD: if (word_valid) begin
          state_q    <= SHIFT;
          shift_en_q <= 1'b1;
          head_q     <= word_data[WORD_W-1];
        end else begin
          word_ready_q <= 1'b1;
        end
        SHIFT: begin
          cnt_q <= cnt_d;
          if (final_bit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (last_bit) begin
            state_q      <= LOAD;
            word_ready_q <= 1'b1;
          end else begin
            shift_en_q <= 1'b1;
            head_q     <= next_bit;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic                      rb_valid_q, unused_rb_next;
  logic [$clog2(WORD_W)-1:0] unused_rb_idx;

  // Word boundaries of the readback match the input words, so the head index marks them.
  assign stall = rb_valid_q && !rb_ready;

  ccff_word_serializer #(.W(WORD_W)) u_rb (
    .clk_i      (prog_clk),
    .reset_i    (reset),
    .load_i     (start_acc),
    .par_i      ('0),
    .step_i     (step),
    .cap_i      (1'b1),
    .ser_i      (ccff_tail),
    .par_o      (rb_data),
    .idx_o      (unused_rb_idx),
    .next_bit_o (unused_rb_next)
  );

  always_ff @(posedge prog_clk) begin
    if (reset || (abort && state_q != IDLE)) rb_valid_q <= 1'b0;
    else if (!stall)                         rb_valid_q <= step && (last_bit || final_bit);
  end

  assign rb_valid = rb_valid_q;
`else
  logic unused_tail, unused_start_acc;
  assign unused_tail      = ccff_tail;
  assign unused_start_acc = start_acc;
  assign stall            = 1'b0;
`endif

  assign word_ready     = word_ready_q && !stall;
  assign ccff_head      = head_q;
  assign chain_shift_en = shift_en_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q && !stall && !abort;
  assign err            = err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader (CHAIN_LEN=18, WORD_W=8) with an 18-bit chain model.
// The readback scenario is compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_chain_loader;

  logic       prog_clk, reset, start, abort, word_valid, word_ready;
  logic       ccff_head, ccff_tail, chain_shift_en, busy, done, err;
  logic [7:0] word_data;
`ifdef CCFF_READBACK_EN
  logic [7:0] rb_data;
  logic       rb_valid, rb_ready;
  logic [7:0] exp_q[$];
  logic [7:0] rb_got_q[$];
`endif

  ccff_chain_loader #(.CHAIN_LEN(18), .WORD_W(8)) dut (
    .prog_clk       (prog_clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .word_data      (word_data),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .ccff_head      (ccff_head),
    .ccff_tail      (ccff_tail),
    .chain_shift_en (chain_shift_en),
    .busy           (busy),
    .done           (done),
    .err            (err)
`ifdef CCFF_READBACK_EN
    ,
    .rb_data        (rb_data),
    .rb_valid       (rb_valid),
    .rb_ready       (rb_ready)
`endif
  );

  // Clock and chain model: first bit shifted in ends up at chain_q[17] (the tail).
  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  logic [17:0] chain_q, preload_val;
  logic        preload;
  always @(posedge prog_clk) begin
    if (preload)             chain_q <= preload_val;
    else if (chain_shift_en) chain_q <= {chain_q[16:0], ccff_head};
  end
  assign ccff_tail = chain_q[17];

  // Scoreboard bookkeeping
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  words [3] = '{8'hA5, 8'h3C, 8'hC0};
  logic [63:0] rdy_m, sh_m, dn_m, hbits;
  int          n_shift, head_bad;
  logic [5:0]  snap;
  localparam logic [17:0] STREAM = 18'b10_1001_0100_1111_0011;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] bits(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [5:0] outs();
    return {word_ready, ccff_head, chain_shift_en, busy, done, err};
  endfunction

  // Drives one load for ncyc cycles; cycle 0 carries the start pulse. -1 disables an event.
  task automatic run_load(input int vstall, input int abort_c, input int reset_c,
                          input int st_a, input int st_b, input int rbst_c,
                          input int snap_c, input int ncyc);
    int widx, vrem;
    widx = 0; vrem = vstall;
    rdy_m = '0; sh_m = '0; dn_m = '0; hbits = '0;
    n_shift = 0; head_bad = 0; snap = 'x;
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0) || (c == st_a) || (c == st_b);
      abort      = (c == abort_c);
      reset      = (c == reset_c);
      word_valid = (widx < 3) && !(widx == 1 && vrem > 0);
      word_data  = (widx < 3) ? words[widx] : 8'h00;
`ifdef CCFF_READBACK_EN
      rb_ready = !(rbst_c >= 0 && c >= rbst_c && c < rbst_c + 3);
`endif
      @(negedge prog_clk);
      if (word_ready) rdy_m[c] = 1'b1;
      if (chain_shift_en) begin
        sh_m[c] = 1'b1;
        n_shift++;
        hbits = {hbits[62:0], ccff_head};
      end else if (ccff_head) begin
        head_bad++;
      end
      if (done) dn_m[c] = 1'b1;
      if (c == snap_c) snap = outs();
      if (word_ready && word_valid) widx++;
      else if (word_ready && widx == 1 && vrem > 0) vrem--;
`ifdef CCFF_READBACK_EN
      if (rb_valid && rb_ready) rb_got_q.push_back(rb_data);
`endif
      @(posedge prog_clk); #1;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; word_valid = 1'b0;
`ifdef CCFF_READBACK_EN
    rb_ready = 1'b1;
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; abort = 1'b0; word_valid = 1'b0; word_data = 8'h00;
    preload = 1'b1; preload_val = '0;
`ifdef CCFF_READBACK_EN
    rb_ready = 1'b1;
`endif

    // 1. Reset held two cycles with start high
    for (int i = 0; i < 2; i++) begin
      @(negedge prog_clk);
      check_eq($sformatf("reset_outs_%0d", i), 64'(outs()), 64'd0);
      @(posedge prog_clk); #1;
    end
    reset = 1'b0; start = 1'b0; preload = 1'b0;
    @(negedge prog_clk);
    check_eq("reset_busy", 64'(busy), 64'd0);
    @(posedge prog_clk); #1;

    // 2. Full load, word_valid always high
    run_load(0, -1, -1, -1, -1, -1, 1, 26);
    check_eq("full_snap_c1", 64'(snap), 64'b100100);
    check_eq("full_ready", rdy_m, bits(1, 1) | bits(10, 10) | bits(19, 19));
    check_eq("full_shift", sh_m, bits(2, 9) | bits(11, 18) | bits(20, 21));
    check_eq("full_done", dn_m, bits(22, 22));
    check_eq("full_nshift", 64'(n_shift), 64'd18);
    check_eq("full_stream", 64'(hbits[17:0]), 64'(STREAM));
    check_eq("full_chain", 64'(chain_q), 64'(STREAM));

    // 3. Five-cycle valid stall in the second LOAD
    run_load(5, -1, -1, -1, -1, -1, 12, 30);
    check_eq("vstall_snap_c12", 64'(snap), 64'b100100);
    check_eq("vstall_ready", rdy_m, bits(1, 1) | bits(10, 15) | bits(24, 24));
    check_eq("vstall_shift", sh_m, bits(2, 9) | bits(16, 23) | bits(25, 26));
    check_eq("vstall_done", dn_m, bits(27, 27));
    check_eq("vstall_stream", 64'(hbits[17:0]), 64'(STREAM));
    check_eq("vstall_head_idle", 64'(head_bad), 64'd0);

    // 4. Abort at the 5th shift of word 2, then a clean reload
    run_load(0, 15, -1, -1, -1, -1, 16, 22);
    check_eq("abort_snap_c16", 64'(snap), 64'b000001);
    check_eq("abort_nshift", 64'(n_shift), 64'd13);
    check_eq("abort_no_done", dn_m, 64'd0);
    check_eq("abort_err_sticky", 64'(err), 64'd1);
    run_load(0, -1, -1, -1, -1, -1, 1, 26);
    check_eq("reload_err_clr", 64'(snap), 64'b100100);
    check_eq("reload_done", dn_m, bits(22, 22));
    check_eq("reload_nshift", 64'(n_shift), 64'd18);

    // 5. Start pulses while shifting are ignored; reset at shift 7
    run_load(0, -1, -1, 4, 12, -1, 22, 26);
    check_eq("busy_start_shift", sh_m, bits(2, 9) | bits(11, 18) | bits(20, 21));
    check_eq("busy_start_done", dn_m, bits(22, 22));
    run_load(0, -1, 8, -1, -1, -1, 9, 16);
    check_eq("midreset_snap_c9", 64'(snap), 64'd0);
    check_eq("midreset_shift", sh_m, bits(2, 8));
    check_eq("midreset_no_done", dn_m, 64'd0);

`ifdef CCFF_READBACK_EN
    // 6. Readback of a preloaded chain with one three-cycle rb_ready stall
    preload_val = {16'h2D71, 2'b10};
    preload = 1'b1;
    @(posedge prog_clk); #1;
    preload = 1'b0;
    rb_got_q.delete();
    exp_q.push_back(8'h2D);
    exp_q.push_back(8'h71);
    exp_q.push_back(8'h80);
    run_load(0, -1, -1, -1, -1, 10, -1, 30);
    check_eq("rb_ready", rdy_m, bits(1, 1) | bits(13, 13) | bits(22, 22));
    check_eq("rb_shift", sh_m, bits(2, 9) | bits(14, 21) | bits(23, 24));
    check_eq("rb_done", dn_m, bits(25, 25));
    check_eq("rb_chain", 64'(chain_q), 64'(STREAM));
    check_eq("rb_count", 64'(rb_got_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      logic [7:0] got, exp;
      exp = exp_q.pop_front();
      got = (rb_got_q.size() != 0) ? rb_got_q.pop_front() : 8'hxx;
      check_eq($sformatf("rb_word_%0d", i), 64'(got), 64'(exp));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
